// File: rtl/data_mem_responder.sv
// Wait-state data memory responder: accepts one read or write request,
// inserts WAIT_CYCLES wait states, then completes with a one-cycle ready
// pulse. Writes are byte-lane masked; read data is held until the next
// read completes.
module data_mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              busy
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LOAD_I = (WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0;
  localparam logic [3:0] CNT_LOAD = LOAD_I[3:0];
  localparam bit HAS_WAIT = (WAIT_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [31:0]         rdata_q, rdata_d;

  // accept: request taken this cycle; commit: this edge enters RESP
  logic                accept;
  logic                commit;

  // Operation seen at the commit edge. With no wait states the commit
  // edge is the accepting edge, so the live inputs are used directly.
  logic                op_we;
  logic [ADDR_W-1:0]   op_addr;
  logic [31:0]         op_wdata;
  logic [3:0]          op_wstrb;
  logic [31:0]         rd_word;

  assign op_we    = accept ? we    : we_q;
  assign op_addr  = accept ? addr  : addr_q;
  assign op_wdata = accept ? wdata : wdata_q;
  assign op_wstrb = accept ? wstrb : wstrb_q;

  // Next-state, counter and request-latch logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          wstrb_d = wstrb;
          if (HAS_WAIT) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = RESP;
            commit  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // requests arriving here are ignored; one idle cycle follows
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Read data is only refreshed by a read completion
  always_comb begin
    rdata_d = rdata_q;
    if (commit && !op_we) begin
      rdata_d = rd_word;
    end
  end

  // Control and datapath registers; memory is deliberately outside reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

  // One byte-wide array per lane so each lane has its own write enable
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gen_lane
      logic [7:0] lane_mem [DEPTH];

      // Commit the enabled byte lane on the edge entering RESP
      always_ff @(posedge clk) begin
        if (commit && op_we && op_wstrb[gi]) begin
          lane_mem[op_addr] <= op_wdata[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = lane_mem[op_addr];
    end
  endgenerate

  assign rdata = rdata_q;
  assign ready = (state_q == RESP);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance with two wait
// states, one with none. Drivers push expected responses; monitors pop
// and compare on every ready pulse.
module tb_data_mem_responder;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        req2 = 1'b0, we2 = 1'b0;
  logic [7:0]  addr2 = 8'h0;
  logic [31:0] wdata2 = 32'h0;
  logic [3:0]  wstrb2 = 4'h0;
  logic [31:0] rdata2;
  logic        ready2, busy2;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [7:0]  addr0 = 8'h0;
  logic [31:0] wdata0 = 32'h0;
  logic [3:0]  wstrb0 = 4'h0;
  logic [31:0] rdata0;
  logic        ready0, busy0;

  exp_t        q2[$];
  exp_t        q0[$];
  logic [31:0] last_rd2 = 32'h0;
  logic [31:0] last_rd0 = 32'h0;

  data_mem_responder #(.WAIT_CYCLES(2), .ADDR_W(8)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2),
    .wdata(wdata2), .wstrb(wstrb2), .rdata(rdata2), .ready(ready2), .busy(busy2)
  );

  data_mem_responder #(.WAIT_CYCLES(0), .ADDR_W(8)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0),
    .wdata(wdata0), .wstrb(wstrb0), .rdata(rdata0), .ready(ready0), .busy(busy0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req_v, cyc);
    end else begin
      $display("ok   %s: %h (cycle %0d)", nm, act, cyc);
    end
  endtask

  // Monitor for the two-wait-state instance
  always @(negedge clk) begin
    if (ready2 === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL dut2 unexpected ready: got ready=1 expected no response (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check({e.name, " latency"}, cyc, e.due);
        check({e.name, " rdata"}, rdata2, e.data);
      end
    end
  end

  // Monitor for the zero-wait-state instance
  always @(negedge clk) begin
    if (ready0 === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL dut0 unexpected ready: got ready=1 expected no response (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check({e.name, " latency"}, cyc, e.due);
        check({e.name, " rdata"}, rdata0, e.data);
      end
    end
  end

  task automatic wait_idle2();
    int n = 0;
    while (busy2 !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy2 !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL dut2 busy timeout: got busy=%b expected 0", busy2);
    end
  endtask

  // One transaction on dut2; inputs are scrambled while busy
  task automatic txn2(input bit w, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] exp_rd, input string nm);
    exp_t e;
    @(negedge clk);
    req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d; wstrb2 = s;
    e.is_rd = !w;
    e.data  = w ? last_rd2 : exp_rd;
    e.due   = cyc + 3;
    e.name  = nm;
    q2.push_back(e);
    if (!w) last_rd2 = exp_rd;
    @(negedge clk);
    req2 = 1'b0; we2 = ~w; addr2 = ~a; wdata2 = ~d; wstrb2 = 4'hF;
    wait_idle2();
  endtask

  // Back-to-back vectors for dut0 with req held high throughout
  bit          v_we   [6] = '{1, 1, 1, 0, 0, 0};
  logic [7:0]  v_addr [6] = '{8'h01, 8'h02, 8'hFF, 8'h01, 8'h02, 8'hFF};
  logic [31:0] v_data [6] = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4,
                              32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};

  initial begin
    repeat (2) @(negedge clk);
    check("dut2 reset ready", {31'h0, ready2}, 32'h0);
    check("dut2 reset busy", {31'h0, busy2}, 32'h0);
    check("dut2 reset rdata", rdata2, 32'h0);
    check("dut0 reset ready", {31'h0, ready0}, 32'h0);
    check("dut0 reset busy", {31'h0, busy0}, 32'h0);
    rst = 1'b1;

    txn2(1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0, "wr 10 DEADBEEF");
    txn2(0, 8'h10, 32'h0, 4'h0, 32'hDEADBEEF, "rd 10");
    txn2(1, 8'h20, 32'h11223344, 4'hF, 32'h0, "wr 20 11223344");
    txn2(1, 8'h20, 32'hAABBCCDD, 4'b0101, 32'h0, "wr 20 lanes 0101");
    txn2(0, 8'h20, 32'h0, 4'h0, 32'h11BB33DD, "rd 20 merged");
    txn2(1, 8'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, "wr 20 strb 0000");
    txn2(0, 8'h20, 32'h0, 4'h0, 32'h11BB33DD, "rd 20 unchanged");
    txn2(1, 8'h10, 32'h55667788, 4'b1010, 32'h0, "wr 10 lanes 1010");
    txn2(0, 8'h10, 32'h0, 4'h0, 32'h55AD77EF, "rd 10 merged");
    txn2(1, 8'hFF, 32'hA5A5A5A5, 4'hF, 32'h0, "wr FF");
    txn2(0, 8'hFF, 32'h0, 4'h0, 32'hA5A5A5A5, "rd FF");
    txn2(1, 8'h05, 32'h01020304, 4'hF, 32'h0, "wr 05 01020304");
    txn2(0, 8'h05, 32'h0, 4'h0, 32'h01020304, "rd 05");

    // zero wait states: accepted every second cycle with req held high
    for (int k = 0; k < 6; k++) begin
      exp_t e;
      @(negedge clk);
      req0 = 1'b1; we0 = v_we[k]; addr0 = v_addr[k]; wdata0 = v_data[k]; wstrb0 = 4'hF;
      e.is_rd = !v_we[k];
      e.data  = v_we[k] ? last_rd0 : v_data[k];
      e.due   = cyc + 1;
      e.name  = v_we[k] ? "dut0 b2b wr" : "dut0 b2b rd";
      q0.push_back(e);
      if (!v_we[k]) last_rd0 = v_data[k];
      @(negedge clk);
    end
    req0 = 1'b0;
    repeat (3) @(negedge clk);

    // reset while a write sits in WAIT
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b1; addr2 = 8'h05; wdata2 = 32'hCAFEF00D; wstrb2 = 4'hF;
    @(negedge clk);
    req2 = 1'b0; addr2 = 8'h00; wdata2 = 32'h0;
    check("dut2 busy in WAIT", {31'h0, busy2}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("dut2 async reset ready", {31'h0, ready2}, 32'h0);
    check("dut2 async reset busy", {31'h0, busy2}, 32'h0);
    check("dut2 async reset rdata", rdata2, 32'h0);
    check("dut0 async reset rdata", rdata0, 32'h0);
    last_rd2 = 32'h0;
    last_rd0 = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    txn2(0, 8'h05, 32'h0, 4'h0, 32'h01020304, "rd 05 after reset");
    txn2(0, 8'h20, 32'h0, 4'h0, 32'h11BB33DD, "rd 20 after reset");

    repeat (4) @(negedge clk);
    check("dut2 queue drained", q2.size(), 32'h0);
    check("dut0 queue drained", q0.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait-state cycles inserted between request acceptance and response (legal range 0..15).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning the word-address width; depth is 2**ADDR_W 32-bit words.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  1  the initiator requests an access; sampled only in IDLE.
REQ-007 SHALL have port we  input  1  1 = write, 0 = read; qualified by req.
REQ-008 SHALL have port addr  input  ADDR_W  word address (initiator drives ALU result bits [9:2]).
REQ-009 SHALL have port wdata  input  32  write data.
REQ-010 SHALL have port wstrb  input  4  byte enables for writes; bit i enables byte lane i (bits 8i+7:8i).
REQ-011 SHALL have port rdata  output  32  read data; valid when ready=1 for a read.
REQ-012 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT, RESP.
REQ-015 In IDLE with req=1 at a rising edge, SHALL latch we, addr, wdata, and wstrb, and go to WAIT when WAIT_CYCLES>0, or to RESP when WAIT_CYCLES=0.
REQ-016 In IDLE with req=0, SHALL remain in IDLE.
REQ-017 On entering WAIT, SHALL load a down-counter with WAIT_CYCLES-1, decrement it each cycle, and go to RESP on the edge where the counter equals 0.
REQ-018 SHALL produce ready=1 exactly WAIT_CYCLES+1 cycles after the accepting edge, for exactly one cycle (the RESP cycle).
REQ-019 SHALL go from RESP to IDLE unconditionally; a req present in RESP SHALL be ignored, giving a minimum of one idle cycle between transactions.
REQ-020 SHALL ignore req, we, addr, wdata, and wstrb while busy=1; only the latched copies are used.
REQ-021 SHALL commit a write on the edge entering RESP, updating only the enabled byte lanes; wstrb=0000 SHALL complete with ready but leave memory unchanged.
REQ-022 SHALL load rdata for a read on the edge entering RESP with the addressed word's current contents; rdata SHALL hold until the next read response.
REQ-023 A write response SHALL NOT change rdata.
REQ-024 A read issued after a completed write to the same address SHALL return the written data, merged per byte lane.
REQ-025 Address arithmetic SHALL use ADDR_W bits only; there is no out-of-range condition.
REQ-026 busy SHALL be high in WAIT and RESP and low in IDLE.
REQ-027 ready and busy SHALL be registered outputs or pure decodes of the FSM state, with no combinational path from req.

Reset
REQ-028 On rst=0, SHALL immediately set the state to IDLE, ready=0, busy=0, rdata=32'h0, and the counter to 0, independent of clk.
REQ-029 Reset asserted during WAIT SHALL drop the pending transaction; an uncommitted write SHALL never reach memory.
REQ-030 Reset SHALL NOT clear memory contents.
REQ-031 After rst returns to 1, the first req SHALL be accepted on the first rising edge.

Verification
REQ-032 WAIT_CYCLES=2: write addr=8'h10, wdata=32'hDEADBEEF, wstrb=4'hF, then read 8'h10 -> each ready pulse arrives 3 cycles after acceptance; read rdata=32'hDEADBEEF.
REQ-033 Byte-lane test: preload 8'h20 with 32'h11223344, then write 32'hAABBCCDD with wstrb=4'b0101 -> read returns 32'h11BB33DD.
REQ-034 WAIT_CYCLES=0: read accepted at edge N -> ready=1 in cycle N+1; back-to-back req held high -> accepted every 2 cycles.
REQ-035 Input-change immunity: change addr and wdata while busy=1 -> transaction uses the values latched at acceptance; rdata is unchanged after a write response.
REQ-036 Reset mid-WAIT: assert rst=0 one cycle after accepting write addr=8'h05 of 32'hCAFEF00D -> ready, busy, and rdata go to 0 asynchronously; a subsequent read of 8'h05 returns the prior contents, not 32'hCAFEF00D.
